// File: rtl/cic_dec_ctrl_if.sv
// Signal bundle between the CIC decimation controller (slave) and its
// environment (master): config, sample source, CIC datapath and result port.
interface cic_dec_ctrl_if #(
  parameter int Win  = 16,
  parameter int Wg   = 22,
  parameter int Wout = 16,
  parameter int SH_W = 6
);
  logic                cfg_start;
  logic                cfg_stop;
  logic [SH_W-1:0]     cfg_shift;
  logic                smp_valid;
  logic [Win-1:0]      smp_data;
  logic                cic_rst;
  logic                cic_val_in;
  logic [Win-1:0]      cic_data_in;
  logic                cic_val_out;
  logic [Win+Wg-1:0]   cic_data_out;
  logic                o_valid;
  logic                o_ready;
  logic [Wout-1:0]     o_data;
  logic                busy;
  logic                overrun;

  modport slave (
    input  cfg_start, cfg_stop, cfg_shift, smp_valid, smp_data,
           cic_val_out, cic_data_out, o_ready,
    output cic_rst, cic_val_in, cic_data_in, o_valid, o_data, busy, overrun
  );

  modport master (
    output cfg_start, cfg_stop, cfg_shift, smp_valid, smp_data,
           cic_val_out, cic_data_out, o_ready,
    input  cic_rst, cic_val_in, cic_data_in, o_valid, o_data, busy, overrun
  );
endinterface

// File: rtl/cic_dec_ctrl.sv
// CIC decimator controller: flush, warm-up discard, shift+saturate gain, valid/ready output.
// Optional round-half-up before the shift when CIC_CTRL_ROUND_EN is defined.
module cic_dec_ctrl #(
  parameter int Win    = 16,
  parameter int Wg     = 22,
  parameter int Wout   = 16,
  parameter int SH_W   = 6,
  parameter int WARMUP = 4
) (
  input  logic           clk,
  input  logic           rst,
  cic_dec_ctrl_if.slave  bus
);
  localparam int          W   = Win + Wg;
  localparam int          WCW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [31:0] WU  = 32'(W);

  typedef enum logic [1:0] {IDLE, FLUSH, WARM, RUN} state_t;

  state_t            state_q;
  logic              flushCnt_q;
  logic [WCW-1:0]    warmCnt_q;
  logic [SH_W-1:0]   shift_q;
  logic              cicRst_q;
  logic              cicValIn_q;
  logic [Win-1:0]    cicDataIn_q;
  logic              oValid_q;
  logic [Wout-1:0]   oData_q;
  logic              busy_q;
  logic              overrun_q;

  logic signed [W-1:0] shifted_d;
  logic [Wout-1:0]     sat_d;
  logic [WCW-1:0]      warmNext_d;
  logic                load_d;

`ifdef CIC_CTRL_ROUND_EN
  logic [W:0]   rnd_d;
  logic [W:0]   sum_d;
  logic [W-1:0] rounded_d;

  // Round half up; a positive overflow clamps to the largest W-bit value.
  // Any shift of W or more leaves nothing but the (non-negative) rounded sign.
  always_comb begin
    rnd_d = '0;
    if (shift_q != '0) rnd_d = (W+1)'(1) << (shift_q - 1'b1);
    sum_d     = {bus.cic_data_out[W-1], bus.cic_data_out} + rnd_d;
    rounded_d = (!sum_d[W] && sum_d[W-1]) ? {1'b0, {(W-1){1'b1}}} : sum_d[W-1:0];
    if (32'(shift_q) >= WU) shifted_d = '0;
    else                    shifted_d = $signed(rounded_d) >>> shift_q;
  end
`else
  always_comb begin
    shifted_d = $signed(bus.cic_data_out) >>> shift_q;
  end
`endif

  always_comb begin
    sat_d = shifted_d[Wout-1:0];
    if (!shifted_d[W-1] && (|shifted_d[W-2:Wout-1]))
      sat_d = {1'b0, {(Wout-1){1'b1}}};
    else if (shifted_d[W-1] && !(&shifted_d[W-2:Wout-1]))
      sat_d = {1'b1, {(Wout-1){1'b0}}};
  end

  assign warmNext_d = warmCnt_q + 1'b1;
  assign load_d     = (state_q == RUN) && bus.cic_val_out && !bus.cfg_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flushCnt_q  <= 1'b0;
      warmCnt_q   <= '0;
      shift_q     <= '0;
      cicRst_q    <= 1'b0;
      cicValIn_q  <= 1'b0;
      cicDataIn_q <= '0;
      oValid_q    <= 1'b0;
      oData_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // A new result beats a same-cycle acceptance and keeps o_valid high.
      if (oValid_q && bus.o_ready) oValid_q <= 1'b0;
      if (load_d) begin
        oValid_q <= 1'b1;
        oData_q  <= sat_d;
        if (oValid_q && !bus.o_ready) overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.cfg_start) begin
            state_q    <= FLUSH;
            shift_q    <= bus.cfg_shift;
            overrun_q  <= 1'b0;
            cicRst_q   <= 1'b1;
            busy_q     <= 1'b1;
            flushCnt_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (bus.cfg_stop) begin
            state_q  <= IDLE;
            cicRst_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (flushCnt_q) begin
            state_q     <= (WARMUP == 0) ? RUN : WARM;
            cicRst_q    <= 1'b0;
            warmCnt_q   <= '0;
            cicValIn_q  <= bus.smp_valid;
            cicDataIn_q <= bus.smp_data;
          end else begin
            flushCnt_q <= 1'b1;
          end
        end
        WARM, RUN: begin
          if (bus.cfg_stop) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cicValIn_q <= 1'b0;
          end else begin
            cicValIn_q  <= bus.smp_valid;
            cicDataIn_q <= bus.smp_data;
            if (state_q == WARM && bus.cic_val_out) begin
              warmCnt_q <= warmNext_d;
              if (warmNext_d == WCW'(WARMUP)) state_q <= RUN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cic_rst     = cicRst_q;
  assign bus.cic_val_in  = cicValIn_q;
  assign bus.cic_data_in = cicDataIn_q;
  assign bus.o_valid     = oValid_q;
  assign bus.o_data      = oData_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: hand-written control sequences plus a
// table of {shift, CIC word, expected o_data} scaling vectors.
module tb_cic_dec_ctrl;
  localparam bit ROUND =
`ifdef CIC_CTRL_ROUND_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [5:0]  shift;
    logic [37:0] din;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  cic_dec_ctrl_if #(.Win(16), .Wg(22), .Wout(16), .SH_W(6)) bus ();

  cic_dec_ctrl #(.Win(16), .Wg(22), .Wout(16), .SH_W(6), .WARMUP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One CIC output strobe carrying the given word.
  task automatic applyStimulus(input logic [37:0] d);
    bus.cic_val_out  = 1'b1;
    bus.cic_data_out = d;
    tick();
    bus.cic_val_out  = 1'b0;
  endtask

  task automatic startRun(input logic [5:0] sh, input bit verbose);
    bus.cfg_shift = sh;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    if (verbose) begin
      checkOutput("flush1_cic_rst", bus.cic_rst, 1);
      checkOutput("flush1_busy", bus.busy, 1);
    end
    tick();
    if (verbose) checkOutput("flush2_cic_rst", bus.cic_rst, 1);
    tick();
    if (verbose) checkOutput("warm_cic_rst", bus.cic_rst, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(38'h1F_0000_0000);
      if (verbose) checkOutput("warmup_no_valid", bus.o_valid, 0);
    end
  endtask

  initial begin
    vecs[0] = '{6'd22, 38'h12_3456_7890, 16'h48D1};
    vecs[1] = '{6'd8,  38'h00_4000_0000, 16'h7FFF};
    vecs[2] = '{6'd8,  38'h3F_C000_0000, 16'h8000};
    vecs[3] = '{6'd4,  38'h00_0000_0018, ROUND ? 16'h0002 : 16'h0001};
    vecs[4] = '{6'd4,  38'h00_0000_0017, 16'h0001};
    vecs[5] = '{6'd0,  38'h00_0000_8000, 16'h7FFF};
    vecs[6] = '{6'd0,  38'h3F_FFFF_FFFF, 16'hFFFF};
    vecs[7] = '{6'd40, 38'h3F_FFFF_FFFB, ROUND ? 16'h0000 : 16'hFFFF};
    vecs[8] = '{6'd1,  38'h3F_FFFF_FFFD, ROUND ? 16'hFFFF : 16'hFFFE};
    vecs[9] = '{6'd22, 38'h1F_FFFF_FFFF, 16'h7FFF};

    bus.cfg_start = 0; bus.cfg_stop = 0; bus.cfg_shift = '0;
    bus.smp_valid = 0; bus.smp_data = '0;
    bus.cic_val_out = 0; bus.cic_data_out = '0; bus.o_ready = 0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_o_valid", bus.o_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_cic_rst", bus.cic_rst, 0);
    checkOutput("rst_overrun", bus.overrun, 0);
    checkOutput("rst_o_data", bus.o_data, 0);

    // Start, flush, warm-up discard, first real result.
    startRun(6'd22, 1'b1);
    applyStimulus(38'h12_3456_7890);
    checkOutput("first_valid", bus.o_valid, 1);
    checkOutput("first_data", bus.o_data, 16'h48D1);
    bus.o_ready = 1'b1; tick(); bus.o_ready = 1'b0;
    checkOutput("accept_clears_valid", bus.o_valid, 0);

    // Backpressure: B overwrites A and raises overrun.
    applyStimulus(38'h00_0040_0000);
    checkOutput("bp_a_data", bus.o_data, 16'h0001);
    checkOutput("bp_a_no_overrun", bus.overrun, 0);
    applyStimulus(38'h00_0080_0000);
    checkOutput("bp_b_data", bus.o_data, 16'h0002);
    checkOutput("bp_overrun", bus.overrun, 1);
    bus.o_ready = 1'b1; tick(); bus.o_ready = 1'b0;
    checkOutput("bp_drain_valid", bus.o_valid, 0);
    checkOutput("bp_overrun_sticky", bus.overrun, 1);

    // Load in the same cycle as acceptance wins.
    applyStimulus(38'h00_00C0_0000);
    bus.o_ready = 1'b1;
    applyStimulus(38'h00_0100_0000);
    bus.o_ready = 1'b0;
    checkOutput("loadwins_valid", bus.o_valid, 1);
    checkOutput("loadwins_data", bus.o_data, 16'h0004);

    // Start+stop together in RUN: stop wins, pending result kept.
    bus.cfg_start = 1'b1; bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_start = 1'b0; bus.cfg_stop = 1'b0;
    checkOutput("stop_busy", bus.busy, 0);
    checkOutput("stop_keeps_valid", bus.o_valid, 1);
    tick();
    checkOutput("start_ignored_cic_rst", bus.cic_rst, 0);
    checkOutput("start_ignored_busy", bus.busy, 0);
    applyStimulus(38'h00_0800_0000);
    checkOutput("post_stop_ignored", bus.o_data, 16'h0004);
    bus.o_ready = 1'b1; tick(); bus.o_ready = 1'b0;
    checkOutput("pending_delivered", bus.o_valid, 0);
    checkOutput("overrun_held_idle", bus.overrun, 1);

    // Next start clears overrun.
    bus.cfg_shift = 6'd22; bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    checkOutput("start_clears_overrun", bus.overrun, 0);
    bus.cfg_stop = 1'b1; tick(); bus.cfg_stop = 1'b0;

    // Sample path in RUN and the dropped sample of the stop cycle.
    startRun(6'd22, 1'b0);
    bus.smp_valid = 1'b1; bus.smp_data = 16'h1234;
    tick();
    checkOutput("smp_val_in", bus.cic_val_in, 1);
    checkOutput("smp_data_in", bus.cic_data_in, 16'h1234);
    bus.smp_valid = 1'b0; bus.smp_data = 16'h0BCD;
    tick();
    checkOutput("smp_val_low", bus.cic_val_in, 0);
    bus.smp_valid = 1'b1; bus.smp_data = 16'h5555; bus.cfg_stop = 1'b1;
    tick();
    bus.smp_valid = 1'b0; bus.cfg_stop = 1'b0;
    checkOutput("stop_drops_val", bus.cic_val_in, 0);
    checkOutput("stop_holds_data", bus.cic_data_in, 16'h0BCD);

    // Reset mid-RUN with a pending result.
    startRun(6'd22, 1'b0);
    applyStimulus(38'h00_0040_0000);
    applyStimulus(38'h00_0080_0000);
    checkOutput("pre_rst_valid", bus.o_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("midrst_o_valid", bus.o_valid, 0);
    checkOutput("midrst_o_data", bus.o_data, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_overrun", bus.overrun, 0);
    checkOutput("midrst_cic_data_in", bus.cic_data_in, 0);
    applyStimulus(38'h00_0040_0000);
    checkOutput("midrst_idle", bus.o_valid, 0);

    // Scaling table.
    for (int i = 0; i < 10; i++) begin
      startRun(vecs[i].shift, 1'b0);
      applyStimulus(vecs[i].din);
      checkOutput($sformatf("vec%0d_valid", i), bus.o_valid, 1);
      checkOutput($sformatf("vec%0d_data", i), bus.o_data, vecs[i].exp);
      bus.o_ready = 1'b1; tick(); bus.o_ready = 1'b0;
      bus.cfg_stop = 1'b1; tick(); bus.cfg_stop = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
Controller that sequences a CIC decimation datapath (Win-bit input, Win+Wg-bit output).
- Gates the sample stream into the CIC.
- Issues a flush reset on each start.
- Discards warm-up outputs.
- Applies runtime gain, selected as an arithmetic shift plus saturation to Wout bits.
- Presents results on a valid/ready port.

It sits between the ADC sample source and the downstream filter/FIFO and replaces a fixed bit-slice truncation.

Parameters:
- Win, 16, CIC input sample width
- Wg, 22, CIC guard bits; CIC output width is Win+Wg
- Wout, 16, output sample width
- SH_W, 6, width of the shift-select field
- WARMUP, 4, number of CIC outputs discarded after each start (0 allowed)

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- cfg_start, in, 1, start pulse; accepted in IDLE only
- cfg_stop, in, 1, stop pulse; accepted in any non-IDLE state
- cfg_shift, in, SH_W, right-shift amount applied to CIC output; latched on start
- smp_valid, in, 1, input sample strobe
- smp_data, in, Win, signed input sample
- cic_rst, out, 1, flush reset to CIC
- cic_val_in, out, 1, sample strobe to CIC
- cic_data_in, out, Win, sample to CIC
- cic_val_out, in, 1, CIC output strobe
- cic_data_out, in, Win+Wg, signed CIC output
- o_valid, out, 1, output sample valid
- o_ready, in, 1, downstream ready
- o_data, out, Wout, signed scaled output
- busy, out, 1, high in any state except IDLE
- overrun, out, 1, sticky flag: an output was overwritten before it was accepted

Behaviour:
- Reset values (rst=1 at a clock edge): state=IDLE; all outputs 0, including overrun.
- FSM states: IDLE, FLUSH, WARM, RUN.
  - IDLE -> FLUSH on cfg_start; cfg_shift is latched on the same edge.
  - FLUSH lasts exactly 2 cycles; cic_rst=1 in both. Then -> WARM, or -> RUN directly if WARMUP=0.
  - WARM: counts cic_val_out pulses; when the count reaches WARMUP -> RUN. Warm-up outputs never reach o_valid.
  - Any non-IDLE state -> IDLE on cfg_stop.
  - cfg_stop has priority over every other transition in the same cycle.
  - cfg_start outside IDLE is ignored.
- Sample path:
  - In WARM and RUN, cic_val_in is smp_valid registered by 1 cycle, and cic_data_in is smp_data registered by 1 cycle.
  - In IDLE and FLUSH, cic_val_in=0 and cic_data_in holds its last value.
  - smp_valid arriving in the stop cycle is dropped.
- Scaling:
  - t = cic_data_out >>> shift (arithmetic shift).
  - If t > 2^(Wout-1)-1, o_data saturates to 2^(Wout-1)-1. If t < -2^(Wout-1), o_data saturates to -2^(Wout-1).
  - shift >= Win+Wg yields the sign extension (0 or -1).
  - shift=22 with Win=16, Wg=22, Wout=16 gives exactly bits [37:22], with no saturation possible.
- Output handshake:
  - A cic_val_out pulse in RUN loads o_data and sets o_valid on the next edge (latency 1).
  - o_valid clears on o_valid && o_ready unless a new result loads in the same cycle; the load wins and o_valid stays 1.
  - If o_valid=1, o_ready=0 and a new result loads: o_data is overwritten and overrun is set.
  - overrun clears only on rst or on cfg_start.
- Stop:
  - On cfg_stop, a pending o_valid is retained until accepted.
  - cic_val_out pulses after stop are ignored.
- busy = (state != IDLE).

Optional Feature:
CIC_CTRL_ROUND_EN
- Defined: before the shift, add 2^(shift-1) when shift > 0 (round half up), then saturate. An add that overflows the Win+Wg range saturates positive.
- Undefined: plain truncation by arithmetic shift.

Test Plan:
- Reset mid-RUN with o_valid=1 -> next cycle all outputs 0, busy=0, state IDLE.
- Start with shift=22, WARMUP=4 -> cic_rst high exactly 2 cycles. First 4 cic_val_out pulses produce no o_valid. 5th pulse with cic_data_out=0x12_3456_7890 -> o_data=0x48D1 one cycle later.
- Saturation with shift=8: cic_data_out=+2^30 -> o_data=0x7FFF; cic_data_out=-2^30 -> o_data=0x8000.
- Backpressure: hold o_ready=0 across two results A then B -> o_data=B, overrun=1. Then o_ready=1 -> o_valid drops after one cycle. Next cfg_start clears overrun.
- cfg_start and cfg_stop in the same cycle while in RUN -> IDLE, start ignored; pending output is still delivered when o_ready=1.
- With CIC_CTRL_ROUND_EN, shift=4: cic_data_out=0x18 -> o_data=2; cic_data_out=0x17 -> o_data=1. Without the macro, both give 1.
